// File: rtl/ppc_pkg.sv
// rtl/ppc_pkg.sv - shared PowerPC opcodes, GPR width and lsm sequencer state type
package ppc_pkg;

  localparam logic [5:0] OP_LMW  = 6'd46;
  localparam logic [5:0] OP_STMW = 6'd47;
  localparam int unsigned GPR_W  = 5;

  typedef enum logic [1:0] {
    LSM_IDLE = 2'd0,
    LSM_BASE = 2'd1,
    LSM_MEM  = 2'd2,
    LSM_DONE = 2'd3
  } lsm_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/lsm_agen.sv
// rtl/lsm_agen.sv - effective-address and register-index counters for load/store multiple
module lsm_agen
  import ppc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      base_ea_i,
  input  logic [GPR_W-1:0] base_cur_i,
  output logic [31:0]      ea_o,
  output logic [GPR_W-1:0] cur_o,
  output logic             last_o
);

  logic [31:0]      ea_q, ea_d;
  logic [GPR_W-1:0] cur_q, cur_d;

  always_comb begin
    ea_d  = ea_q;
    cur_d = cur_q;
    if (load_i) begin
      ea_d  = base_ea_i;
      cur_d = base_cur_i;
    end else if (step_i) begin
      // wraps silently past 2^32, matching the architected EA arithmetic
      ea_d  = ea_q + 32'd4;
      cur_d = cur_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q  <= '0;
      cur_q <= '0;
    end else begin
      ea_q  <= ea_d;
      cur_q <= cur_d;
    end
  end

  assign ea_o   = ea_q;
  assign cur_o  = cur_q;
  assign last_o = (cur_q == {GPR_W{1'b1}});

endmodule

// File: rtl/lsm_seq.sv
// rtl/lsm_seq.sv - lmw/stmw sequencer driving GPR read/write ports and the data-memory port
module lsm_seq
  import ppc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op,
  output logic [GPR_W-1:0] gpr_raddr,
  input  logic [31:0]      gpr_rdata,
  output logic             gpr_we,
  output logic [GPR_W-1:0] gpr_waddr,
  output logic [31:0]      gpr_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             done,
  output logic             illegal
);

  lsm_state_t       state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic             flag_q, flag_d;

  logic [5:0]       opc_in;
  logic [5:0]       opc_q;
  logic [GPR_W-1:0] rd_q;
  logic [GPR_W-1:0] ra_q;
  logic [31:0]      base_ea;
  logic             is_store;

  logic             agen_load;
  logic             agen_step;
  logic [31:0]      ea;
  logic [GPR_W-1:0] cur;
  logic             last;

  assign opc_in   = op[31:26];
  assign opc_q    = op_q[31:26];
  assign rd_q     = op_q[25:21];
  assign ra_q     = op_q[20:16];
  assign is_store = (opc_q == OP_STMW);

  // rA==0 means a literal zero base, not the contents of r0
  assign base_ea = ((ra_q == '0) ? 32'd0 : gpr_rdata) + sext16(op_q[15:0]);

  lsm_agen u_agen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (agen_load),
    .step_i     (agen_step),
    .base_ea_i  (base_ea),
    .base_cur_i (rd_q),
    .ea_o       (ea),
    .cur_o      (cur),
    .last_o     (last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    flag_d    = flag_q;
    agen_load = 1'b0;
    agen_step = 1'b0;
    unique case (state_q)
      LSM_IDLE: begin
        if (op_valid) begin
          op_d = op;
          if (opc_in == OP_LMW || opc_in == OP_STMW) begin
            state_d = LSM_BASE;
          end else begin
            state_d = LSM_DONE;
            flag_d  = 1'b1;
          end
        end
      end
      LSM_BASE: begin
        agen_load = 1'b1;
        if (base_ea[1:0] != 2'b00) begin
          state_d = LSM_DONE;
          flag_d  = 1'b1;
        end else begin
          state_d = LSM_MEM;
        end
      end
      LSM_MEM: begin
        if (mem_ack) begin
          if (last) begin
            state_d = LSM_DONE;
          end else begin
            agen_step = 1'b1;
          end
        end
      end
      LSM_DONE: begin
        flag_d  = 1'b0;
        state_d = LSM_IDLE;
      end
      default: state_d = LSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSM_IDLE;
      op_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    op_ready  = 1'b0;
    gpr_raddr = '0;
    gpr_we    = 1'b0;
    gpr_waddr = '0;
    gpr_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      LSM_IDLE: op_ready = 1'b1;
      LSM_BASE: gpr_raddr = ra_q;
      LSM_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_addr = ea;
        if (is_store) begin
          gpr_raddr = cur;
          mem_wdata = gpr_rdata;
        end else if (mem_ack) begin
          gpr_we    = 1'b1;
          gpr_waddr = cur;
          gpr_wdata = mem_rdata;
        end
      end
      LSM_DONE: begin
        done    = 1'b1;
        illegal = flag_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsm_seq.sv
// tb/tb_lsm_seq.sv - directed self-checking bench for lsm_seq
module tb_lsm_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op = '0;
  logic [4:0]  gpr_raddr;
  logic [31:0] gpr_rdata;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        illegal;

  always #5 clk = ~clk;

  lsm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .gpr_raddr (gpr_raddr),
    .gpr_rdata (gpr_rdata),
    .gpr_we    (gpr_we),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (done),
    .illegal   (illegal)
  );

  logic [31:0] gpr [32];
  logic [31:0] ld_data [32];
  logic [31:0] log_addr [512];
  logic [31:0] log_wdata [512];
  logic        log_we [512];
  int          log_n = 0;
  int          beat = 0;
  int          beat_base = 0;
  int          gpr_wr_n = 0;
  int          req_n = 0;
  int          unstable_n = 0;
  int          wcnt = 0;
  int          wait_cfg = 0;
  logic        ack_force = 1'b0;
  logic        held = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  assign gpr_rdata = gpr[gpr_raddr];
  assign mem_ack   = ack_force | (mem_req && (wcnt == wait_cfg));
  assign mem_rdata = ld_data[5'(beat - beat_base)];

  always @(posedge clk) begin
    if (gpr_we) begin
      gpr[gpr_waddr] <= gpr_wdata;
      gpr_wr_n <= gpr_wr_n + 1;
    end
    if (mem_req) req_n <= req_n + 1;
    if (mem_req && mem_ack) begin
      log_addr[log_n[8:0]]  <= mem_addr;
      log_wdata[log_n[8:0]] <= mem_wdata;
      log_we[log_n[8:0]]    <= mem_we;
      log_n <= log_n + 1;
      beat  <= beat + 1;
    end
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (held && mem_req && (mem_addr != prev_addr || mem_wdata != prev_wd))
      unstable_n <= unstable_n + 1;
    held      <= mem_req && !mem_ack;
    prev_addr <= mem_addr;
    prev_wd   <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // cycle 0 is the accept edge; returns the cycle in which done was sampled high
  task automatic run_op(input logic [31:0] word, output int done_cyc, output logic ill);
    int cyc;
    @(negedge clk);
    check_eq("ready_before_accept", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op = word;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op = '0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    done_cyc = done ? cyc : 999;
    ill = illegal;
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  int   dc;
  logic il;
  int   l0, r0, w0, u0, b0, wr0, cyc;

  initial begin
    for (int i = 0; i < 32; i++) begin
      gpr[i] = 32'h0;
      ld_data[i] = 32'h0;
    end

    @(negedge clk);
    check_eq("rst_ctrl", {26'd0, op_ready, mem_req, mem_we, gpr_we, done, illegal}, 32'h20);
    check_eq("rst_addr", mem_addr | mem_wdata | gpr_wdata | {27'd0, gpr_raddr | gpr_waddr}, 32'h0);
    rst = 1'b0;

    // lmw r29,8(r1)
    gpr[1] = 32'h1000;
    beat_base = beat;
    ld_data[0] = 32'hA; ld_data[1] = 32'hB; ld_data[2] = 32'hC;
    l0 = log_n;
    run_op(32'hBBA10008, dc, il);
    check_eq("lmw_done_cyc", dc, 5);
    check_eq("lmw_illegal", {31'd0, il}, 0);
    check_eq("lmw_beats", log_n - l0, 3);
    check_eq("lmw_a0", log_addr[l0],   32'h1008);
    check_eq("lmw_a1", log_addr[l0+1], 32'h100C);
    check_eq("lmw_a2", log_addr[l0+2], 32'h1010);
    check_eq("lmw_we", {31'd0, log_we[l0] | log_we[l0+2]}, 0);
    check_eq("lmw_r29", gpr[29], 32'hA);
    check_eq("lmw_r30", gpr[30], 32'hB);
    check_eq("lmw_r31", gpr[31], 32'hC);

    // stmw r30,-4(r0)
    gpr[30] = 32'h11; gpr[31] = 32'h22;
    l0 = log_n; w0 = gpr_wr_n;
    run_op(32'hBFC0FFFC, dc, il);
    check_eq("stmw_done_cyc", dc, 4);
    check_eq("stmw_beats", log_n - l0, 2);
    check_eq("stmw_a0", log_addr[l0], 32'hFFFFFFFC);
    check_eq("stmw_d0", log_wdata[l0], 32'h11);
    check_eq("stmw_a1_wrap", log_addr[l0+1], 32'h0);
    check_eq("stmw_d1", log_wdata[l0+1], 32'h22);
    check_eq("stmw_we", {31'd0, log_we[l0] & log_we[l0+1]}, 1);
    check_eq("stmw_no_gpr_wr", gpr_wr_n - w0, 0);

    // stmw r31,0(r2) with three wait states
    gpr[2] = 32'h40; gpr[31] = 32'h5555;
    wait_cfg = 3;
    l0 = log_n; r0 = req_n; u0 = unstable_n;
    run_op(32'hBFE20000, dc, il);
    wait_cfg = 0;
    check_eq("wait_done_cyc", dc, 6);
    check_eq("wait_req_cycles", req_n - r0, 4);
    check_eq("wait_stable", unstable_n - u0, 0);
    check_eq("wait_beats", log_n - l0, 1);
    check_eq("wait_addr", log_addr[l0], 32'h40);
    check_eq("wait_data", log_wdata[l0], 32'h5555);

    // opcode 32 rejected
    r0 = req_n; w0 = gpr_wr_n;
    run_op(32'h80000000, dc, il);
    check_eq("badop_done_cyc", dc, 1);
    check_eq("badop_illegal", {31'd0, il}, 1);
    check_eq("badop_no_activity", (req_n - r0) + (gpr_wr_n - w0), 0);
    @(negedge clk);
    check_eq("illegal_cleared", {30'd0, done, illegal}, 0);

    // lmw r5,2(r0) misaligned
    r0 = req_n; w0 = gpr_wr_n;
    run_op(32'hB8A00002, dc, il);
    check_eq("misal_done_cyc", dc, 2);
    check_eq("misal_illegal", {31'd0, il}, 1);
    check_eq("misal_no_activity", (req_n - r0) + (gpr_wr_n - w0), 0);

    // reset during the third beat of lmw r0,0(r0)
    beat_base = beat;
    b0 = beat;
    @(negedge clk);
    op_valid = 1'b1; op = 32'hB8000000;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op = '0;
    cyc = 0;
    while ((beat - b0) < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rstmid_reached_beat3", {31'd0, mem_req}, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_outputs", {26'd0, op_ready, mem_req, mem_we, gpr_we, done, illegal}, 32'h20);
    check_eq("rstmid_addr", mem_addr, 32'h0);
    wr0 = gpr_wr_n;
    ack_force = 1'b1;
    #1;
    check_eq("rstmid_ack_no_we", {31'd0, gpr_we}, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_no_gpr_write", gpr_wr_n - wr0, 0);
    ack_force = 1'b0;
    rst = 1'b0;
    beat_base = beat;
    ld_data[0] = 32'h77;
    run_op(32'hBBE00000, dc, il);
    check_eq("after_rst_done_cyc", dc, 3);
    check_eq("after_rst_r31", gpr[31], 32'h77);

    // lmw r3,0(r4) with r4 inside the loaded range
    gpr[4] = 32'h200;
    beat_base = beat;
    for (int i = 0; i < 32; i++) ld_data[i] = 32'h1000 + i;
    l0 = log_n;
    run_op(32'hB8640000, dc, il);
    check_eq("inrange_done_cyc", dc, 31);
    check_eq("inrange_beats", log_n - l0, 29);
    check_eq("inrange_a2", log_addr[l0+2], 32'h208);
    check_eq("inrange_alast", log_addr[l0+28], 32'h270);
    check_eq("inrange_r4", gpr[4], 32'h1001);
    check_eq("inrange_r31", gpr[31], 32'h101C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsm_seq.md
# lsm_seq

Multi-cycle sequencer for the PowerPC load/store-multiple instructions (lmw, opcode 46; stmw, opcode 47). It accepts one instruction word from the issue stage and computes the effective address. It then walks registers rD/rS through r31, issuing one word memory access per register. It drives the GPR file read port and write port and the data-memory port directly, and holds off further issue until the instruction completes.

## Interface
Parameters: none.

Ports:
- clk — in — 1 — clock; all state updates on the rising edge.
- rst — in — 1 — asynchronous, active-high reset.
- op_valid — in — 1 — instruction word on `op` is valid.
- op_ready — out — 1 — block can accept an instruction.
- op — in — 32 — instruction word, using standard PowerPC D-form fields:
  - opcode = op[31:26]
  - rD/rS = op[25:21]
  - rA = op[20:16]
  - d = sign-extended op[15:0]
- gpr_raddr — out — 5 — GPR read address; the register file reads it combinationally.
- gpr_rdata — in — 32 — GPR read data, same cycle.
- gpr_we — out — 1 — GPR write enable.
- gpr_waddr — out — 5 — GPR write address.
- gpr_wdata — out — 32 — GPR write data.
- mem_req — out — 1 — memory access request.
- mem_we — out — 1 — 1 = store, 0 = load; valid while mem_req.
- mem_addr — out — 32 — word address; valid while mem_req.
- mem_wdata — out — 32 — store data; valid while mem_req && mem_we.
- mem_ack — in — 1 — access completes this cycle.
- mem_rdata — in — 32 — load data; valid with mem_ack.
- done — out — 1 — one-cycle pulse when the instruction retires.
- illegal — out — 1 — asserted together with done if the instruction was rejected.

## Operation
States: IDLE, BASE, MEM, DONE.

- **IDLE**
  - op_ready=1; all other outputs are 0.
  - On op_valid, latch op and go to BASE.
  - If the opcode is neither 46 nor 47, go to DONE with the illegal flag set instead.
- **BASE**
  - Drive gpr_raddr=rA.
  - Register ea = (rA==0 ? 0 : gpr_rdata) + d. The sum is modulo 2^32 and wraps silently.
  - Register cur = rD.
  - If ea[1:0]≠0, go to DONE with illegal set; no memory access is made.
  - Otherwise go to MEM.
- **MEM**
  - mem_req=1, mem_addr=ea, mem_we=(opcode==47).
  - Store: gpr_raddr=cur and mem_wdata=gpr_rdata.
  - On mem_ack:
    - Load: gpr_we=1, gpr_waddr=cur, gpr_wdata=mem_rdata in the same cycle.
    - If cur==31, go to DONE.
    - Otherwise cur←cur+1 and ea←ea+4, and stay in MEM.
  - mem_req stays high across beats; the address changes the cycle after each ack.
- **DONE**
  - done=1, illegal=flag.
  - Clear the flag and return to IDLE.
- **Register count:** 32−rD. rD=31 gives one beat; rD=0 gives 32 beats.
- **rA inside the loaded range:** the base is captured in BASE, so addresses are unaffected. rA is overwritten by the load; this is not flagged.
- **Store data:** stmw with rA in range stores the current GPR value. Store data is combinational from the GPR file; no other writer exists during the sequence.

## Timing
- **Reset values:** while rst is high, and immediately on assertion, state=IDLE, ea=0, cur=0, flag=0. Every output is 0 except op_ready=1.
- **Reset mid-sequence:** any in-flight memory request is abandoned, and a late mem_ack is ignored in IDLE.
- **Accept edge:** cycle 0 is the edge with op_valid&&op_ready.
  - BASE occupies cycle 1.
  - MEM beats start at cycle 2.
  - With zero-wait ack, the sequence takes n cycles and done pulses in cycle n+2.
  - The next op can be accepted in cycle n+3.
- **Wait states:** each extends the current beat by one cycle. mem_addr, mem_we and mem_wdata are stable until ack.
- **Early rejection:** illegal opcodes reach done at cycle 1; misaligned addresses reach done at cycle 2.
- **Ack outside MEM:** mem_ack in any state other than MEM is ignored.

## Structure
- Shared package ppc_pkg holds:
  - OP_LMW=6'd46 and OP_STMW=6'd47;
  - the lsm_state_t enum (IDLE, BASE, MEM, DONE);
  - the GPR index width constant (5).
- Sub-module lsm_agen holds the ea/cur counters:
  - load-from-BASE, increment-on-ack, last = (cur==31).
- The FSM, handshake and port muxing stay in lsm_seq.

## Test plan
- **lmw r29,8(r1)**, r1=0x1000, zero-wait memory returning 0xA,0xB,0xC:
  - reads at 0x1008/0x100C/0x1010;
  - writes r29=0xA, r30=0xB, r31=0xC;
  - done in cycle 5.
- **stmw r30,-4(r0)**, r30=0x11, r31=0x22:
  - stores 0x11@0xFFFFFFFC, then 0x22@0x00000000 (wrap);
  - done in cycle 4.
- **stmw r31,0(r2)** with 3 wait states:
  - mem_req/addr/wdata are held for 4 cycles;
  - one store, done in cycle 6.
- **Rejections:**
  - opcode 32 → done+illegal in cycle 1, with no GPR or memory activity;
  - lmw r5,2(r0) → done+illegal in cycle 2, with no mem_req.
- **Reset mid-op:** assert rst during the third beat of lmw r0,0(r0) →
  - outputs go to reset values immediately;
  - a mem_ack in the next cycle causes no GPR write;
  - a new op is accepted after release.
- **Base inside range:** lmw r3,0(r4), r4=0x200 → addresses are unaffected by r4 being overwritten at beat 2.
